// File: rtl/resolution_text_renderer_pkg.sv
// Shared definitions for the text renderers: ROM geometry, scale factor and
// the renderer FSM state encoding.
// Optional build macro: RESOLUTION_TEXT_SCALE2X_EN (2x horizontal/vertical scaling).
package resolution_text_renderer_pkg;

  localparam int RESLINE_SIZE = 16;  // bits per pre-rendered glyph row
  localparam int RES_ROWS     = 16;  // glyph rows stored in ROM

`ifdef RESOLUTION_TEXT_SCALE2X_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ARMED = 3'd3,
    ST_SHIFT = 3'd4
  } render_state_e;

endpackage

// File: rtl/resolution_text_renderer_text_row_shifter.sv
// Row shift register for the text renderer: loads one glyph row, emits its
// MSB each pixel, shifts every SCALE pixels and counts the pixels remaining.
// Optional build macro: RESOLUTION_TEXT_SCALE2X_EN adds the 2-pixel hold.
module text_row_shifter
  import resolution_text_renderer_pkg::*;
#(
  parameter int WIDTH = RESLINE_SIZE
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             step,
  output logic             msb,
  output logic             done
);

  localparam int CW = $clog2(WIDTH * SCALE + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH * SCALE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef RESOLUTION_TEXT_SCALE2X_EN
  logic             hold_q, hold_d;
`endif

  // Next-state for the shift register, pixel counter and (2x) hold phase.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
`ifdef RESOLUTION_TEXT_SCALE2X_EN
    hold_d = hold_q;
`endif
    if (load) begin
      sr_d  = load_data;
      cnt_d = '0;
`ifdef RESOLUTION_TEXT_SCALE2X_EN
      hold_d = 1'b0;
`endif
    end else if (start || step) begin
      // The start pixel is consumed in the same cycle the count is loaded.
      cnt_d = (start ? CNT_FULL : cnt_q) - CNT_ONE;
`ifdef RESOLUTION_TEXT_SCALE2X_EN
      if (hold_q) begin
        sr_d   = {sr_q[WIDTH-2:0], 1'b0};
        hold_d = 1'b0;
      end else begin
        hold_d = 1'b1;
      end
`else
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
`endif
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
`ifdef RESOLUTION_TEXT_SCALE2X_EN
      hold_q <= 1'b0;
`endif
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
`ifdef RESOLUTION_TEXT_SCALE2X_EN
      hold_q <= hold_d;
`endif
    end
  end

  assign msb  = sr_q[WIDTH-1];
  assign done = (cnt_q == CNT_ONE);

endmodule

// File: rtl/resolution_text_renderer.sv
// Resolution text overlay: fetches one ROM glyph row per in-window video line
// and serialises it into a registered 1-bit overlay aligned to counterX.
// Optional build macro: RESOLUTION_TEXT_SCALE2X_EN (each bit 2 pixels, each row 2 lines).
module resolution_text_renderer
  import resolution_text_renderer_pkg::*;
#(
  parameter int WIDTH   = RESLINE_SIZE,
  parameter int X_START = 32,
  parameter int Y_START = 32,
  parameter int ROWS    = RES_ROWS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [11:0]      counterX,
  input  logic [11:0]      counterY,
  input  logic             line_start,
  output logic [3:0]       rom_addr,
  input  logic [WIDTH-1:0] rom_q,
  output logic             pixel_on,
  output logic             active,
  output logic             underrun
);

  localparam logic [12:0] Y_LO  = 13'(Y_START);
  localparam logic [12:0] Y_HI  = 13'(Y_START + ROWS * SCALE);
  localparam logic [12:0] Y_DIV = 13'(SCALE);
  localparam logic [11:0] X_ST  = 12'(X_START);

  render_state_e state_q, state_d;
  logic [3:0] rom_addr_q, rom_addr_d;
  logic       pixel_on_q, pixel_on_d;
  logic       active_q, active_d;
  logic       underrun_q, underrun_d;
  logic       skip_q, skip_d;   // line already lost to underrun: load but do not arm

  logic [12:0] y_ext_s, y_off_s;
  logic [3:0]  row_s;
  logic        in_window_s, fetch_req_s, at_x_start_s;
  logic        load_s, start_s, step_s, msb_s, done_s;

  // Window compare in 13 bits so the subtraction cannot wrap.
  always_comb begin
    y_ext_s      = {1'b0, counterY};
    y_off_s      = y_ext_s - Y_LO;
    in_window_s  = (y_ext_s >= Y_LO) && (y_ext_s < Y_HI);
    row_s        = 4'(y_off_s / Y_DIV);
    fetch_req_s  = line_start && in_window_s;
    at_x_start_s = (counterX == X_ST);
  end

  // Renderer FSM: next state, ROM address, shifter controls and pixel outputs.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    skip_d     = skip_q;
    underrun_d = underrun_q;
    pixel_on_d = 1'b0;
    active_d   = 1'b0;
    load_s     = 1'b0;
    start_s    = 1'b0;
    step_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req_s) begin
          rom_addr_d = row_s;
          skip_d     = 1'b0;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (at_x_start_s) begin
          underrun_d = 1'b1;
          skip_d     = 1'b1;
        end else begin
          skip_d = skip_q;
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        load_s = 1'b1;
        if (at_x_start_s || skip_q) begin
          underrun_d = underrun_q | at_x_start_s;
          skip_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (line_start) begin
          // New line abandons this one; take the IDLE decision right now.
          if (fetch_req_s) begin
            rom_addr_d = row_s;
            skip_d     = 1'b0;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (at_x_start_s) begin
          start_s    = 1'b1;
          pixel_on_d = msb_s;
          active_d   = 1'b1;
          state_d    = ST_SHIFT;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_SHIFT: begin
        if (line_start) begin
          if (fetch_req_s) begin
            rom_addr_d = row_s;
            skip_d     = 1'b0;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          step_s     = 1'b1;
          pixel_on_d = msb_s;
          active_d   = 1'b1;
          state_d    = done_s ? ST_IDLE : ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= 4'd0;
      pixel_on_q <= 1'b0;
      active_q   <= 1'b0;
      underrun_q <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      pixel_on_q <= pixel_on_d;
      active_q   <= active_d;
      underrun_q <= underrun_d;
      skip_q     <= skip_d;
    end
  end

  text_row_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load_s),
    .load_data (rom_q),
    .start     (start_s),
    .step      (step_s),
    .msb       (msb_s),
    .done      (done_s)
  );

  assign rom_addr = rom_addr_q;
  assign pixel_on = pixel_on_q;
  assign active   = active_q;
  assign underrun = underrun_q;

endmodule
